// File: rtl/alu_rr_sequencer.sv
// rtl/alu_rr_sequencer.sv - round-robin sequencer sharing one registered ALU between two requesters
module alu_rr_sequencer #(
    parameter int OP_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*OP_WIDTH-1:0] req_a,
    input  logic [2*OP_WIDTH-1:0] req_b,
    input  logic [7:0]            req_fun,
    output logic [OP_WIDTH-1:0]   alu_a,
    output logic [OP_WIDTH-1:0]   alu_b,
    output logic [3:0]            alu_fun,
    input  logic [2*OP_WIDTH-1:0] alu_arith_out,
    input  logic                  alu_arith_flag,
    input  logic [OP_WIDTH-1:0]   alu_logic_out,
    input  logic                  alu_logic_flag,
    input  logic [OP_WIDTH-1:0]   alu_cmp_out,
    input  logic                  alu_cmp_flag,
    input  logic [OP_WIDTH-1:0]   alu_shift_out,
    input  logic                  alu_shift_flag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [2*OP_WIDTH-1:0] rsp_data,
    output logic                  rsp_flag,
    output logic                  busy,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t state;
    logic   rr_ptr;
    logic   owner;
    logic   winner;
    logic   accept;

    logic [2*OP_WIDTH-1:0] unit_data;
    logic                  unit_flag;

    // Winner is the priority requester if it is asking, otherwise the other one.
    always_comb begin
        winner    = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
        req_ready = 2'b00;
        if (!RST && state == ST_IDLE && (|req_valid)) begin
            req_ready = winner ? 2'b10 : 2'b01;
        end
        accept = |(req_valid & req_ready);
        busy   = (state != ST_IDLE);
    end

    // Select the unit output addressed by alu_fun[3:2]; narrow units are zero-extended.
    always_comb begin
        unit_data = '0;
        unit_flag = 1'b0;
        case (alu_fun[3:2])
            2'b00: begin
                unit_data = alu_arith_out;
                unit_flag = alu_arith_flag;
            end
            2'b01: begin
                unit_data = {{OP_WIDTH{1'b0}}, alu_logic_out};
                unit_flag = alu_logic_flag;
            end
            2'b10: begin
                unit_data = {{OP_WIDTH{1'b0}}, alu_cmp_out};
                unit_flag = alu_cmp_flag;
            end
            default: begin
                unit_data = {{OP_WIDTH{1'b0}}, alu_shift_out};
                unit_flag = alu_shift_flag;
            end
        endcase
    end

    // Operation sequencer: accept, drive ALU, capture result, hold until consumed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_flag  <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_a   <= winner ? req_a[2*OP_WIDTH-1:OP_WIDTH] : req_a[OP_WIDTH-1:0];
                        alu_b   <= winner ? req_b[2*OP_WIDTH-1:OP_WIDTH] : req_b[OP_WIDTH-1:0];
                        alu_fun <= winner ? req_fun[7:4] : req_fun[3:0];
                        owner   <= winner;
                        rr_ptr  <= ~winner;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    rsp_data  <= unit_data;
                    rsp_flag  <= unit_flag;
                    rsp_id    <= owner;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb/tb_alu_rr_sequencer.sv - scoreboard bench for alu_rr_sequencer with a behavioural registered ALU
module tb_alu_rr_sequencer;

    localparam int W = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [7:0]    req_fun;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [3:0]    alu_fun;
    logic [2*W-1:0] alu_arith_out;
    logic          alu_arith_flag;
    logic [W-1:0]  alu_logic_out;
    logic          alu_logic_flag;
    logic [W-1:0]  alu_cmp_out;
    logic          alu_cmp_flag;
    logic [W-1:0]  alu_shift_out;
    logic          alu_shift_flag;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [2*W-1:0] rsp_data;
    logic          rsp_flag;
    logic          busy;
    logic [15:0]   op_count;

    always #5 CLK = ~CLK;

    alu_rr_sequencer #(.OP_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_arith_out(alu_arith_out), .alu_arith_flag(alu_arith_flag),
        .alu_logic_out(alu_logic_out), .alu_logic_flag(alu_logic_flag),
        .alu_cmp_out(alu_cmp_out), .alu_cmp_flag(alu_cmp_flag),
        .alu_shift_out(alu_shift_out), .alu_shift_flag(alu_shift_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag),
        .busy(busy), .op_count(op_count)
    );

    function automatic logic [31:0] f_arith(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
        case (s)
            2'b00:   return {16'h0, a} + {16'h0, b};
            2'b01:   return {16'h0, a - b};
            2'b10:   return {16'h0, a} * {16'h0, b};
            default: return (b == 16'h0) ? 32'h0 : {16'h0, a / b};
        endcase
    endfunction

    function automatic logic [15:0] f_logic(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
        case (s)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    function automatic logic [15:0] f_cmp(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
        case (s)
            2'b00:   return 16'h0;
            2'b01:   return (a == b) ? 16'h1 : 16'h0;
            2'b10:   return (a > b) ? 16'h2 : 16'h0;
            default: return (a < b) ? 16'h3 : 16'h0;
        endcase
    endfunction

    function automatic logic [15:0] f_shift(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
        case (s)
            2'b00:   return a >> 1;
            2'b01:   return a << 1;
            2'b10:   return b >> 1;
            default: return b << 1;
        endcase
    endfunction

    // Behavioural ALU: every unit registers its result each cycle; the flag marks the addressed unit.
    always @(posedge CLK) begin
        alu_arith_out  <= f_arith(alu_a, alu_b, alu_fun[1:0]);
        alu_logic_out  <= f_logic(alu_a, alu_b, alu_fun[1:0]);
        alu_cmp_out    <= f_cmp(alu_a, alu_b, alu_fun[1:0]);
        alu_shift_out  <= f_shift(alu_a, alu_b, alu_fun[1:0]);
        alu_arith_flag <= (alu_fun[3:2] == 2'b00);
        alu_logic_flag <= (alu_fun[3:2] == 2'b01);
        alu_cmp_flag   <= (alu_fun[3:2] == 2'b10);
        alu_shift_flag <= (alu_fun[3:2] == 2'b11);
    end

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        flag;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   accept_cyc = 0;
    int   rsp_lat    = -1;
    int   rsp_count  = 0;
    logic rsp_prev   = 1'b0;
    logic        last_id;
    logic [31:0] last_data;
    logic        last_flag;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Monitor: push expected results on accept, pop and compare on response handshake.
    always @(negedge CLK) begin
        exp_t e;
        exp_t got;
        if (!RST) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    logic [15:0] a;
                    logic [15:0] b;
                    logic [3:0]  f;
                    a = req_a[i*W +: W];
                    b = req_b[i*W +: W];
                    f = req_fun[i*4 +: 4];
                    e.id = i[0];
                    e.flag = 1'b1;
                    case (f[3:2])
                        2'b00:   e.data = f_arith(a, b, f[1:0]);
                        2'b01:   e.data = {16'h0, f_logic(a, b, f[1:0])};
                        2'b10:   e.data = {16'h0, f_cmp(a, b, f[1:0])};
                        default: e.data = {16'h0, f_shift(a, b, f[1:0])};
                    endcase
                    sb.push_back(e);
                    grants.push_back(i);
                    accept_cyc = cyc;
                end
            end
            if (rsp_valid && !rsp_prev) rsp_lat = cyc - accept_cyc;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    check("sb_id", {31'd0, rsp_id}, {31'd0, got.id});
                    check("sb_data", rsp_data, got.data);
                    check("sb_flag", {31'd0, rsp_flag}, {31'd0, got.flag});
                end
                last_id   = rsp_id;
                last_data = rsp_data;
                last_flag = rsp_flag;
                rsp_count++;
            end
        end
        rsp_prev = rsp_valid;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_accept(input int id);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (req_ready[id]) break;
        end
        check("accept_seen", {31'd0, req_ready[id]}, 32'd1);
        step();
        req_valid[id] = 1'b0;
    endtask

    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        req_a[id*W +: W]   = a;
        req_b[id*W +: W]   = b;
        req_fun[id*4 +: 4] = f;
        req_valid[id]      = 1'b1;
        wait_accept(id);
    endtask

    task automatic wait_rsp(input int n);
        for (int k = 0; k < 60; k++) begin
            if (rsp_count >= n) break;
            @(posedge CLK);
            #2;
        end
        check("rsp_seen", {31'd0, rsp_count >= n}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        RST       = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_fun   = '0;
        rsp_ready = 1'b0;

        // 1. reset
        repeat (2) step();
        @(negedge CLK);
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        step();
        RST       = 1'b0;
        req_valid = 2'b00;
        step();

        // 2. single add with latency
        rsp_ready = 1'b1;
        issue(0, 16'h0005, 16'h0003, 4'b0000);
        wait_rsp(1);
        check("add_latency", rsp_lat, 32'd3);
        check("add_data", last_data, 32'h0000_0008);
        check("add_id", {31'd0, last_id}, 32'd0);
        check("add_op_count", {16'd0, op_count}, 32'd1);

        // 3. full-width multiply
        step();
        issue(1, 16'hFFFF, 16'hFFFF, 4'b0010);
        wait_rsp(2);
        check("mul_data", last_data, 32'hFFFE_0001);
        check("mul_id", {31'd0, last_id}, 32'd1);

        // 4. both requesters continuously valid: strict alternation
        step();
        grants.delete();
        req_a     = {16'h8001, 16'h00F0};
        req_b     = {16'h0000, 16'h0F0F};
        req_fun   = {4'b1101, 4'b0101};
        req_valid = 2'b11;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            if (grants.size() >= 4) break;
        end
        req_valid = 2'b00;
        wait_rsp(6);
        check("arb_count", grants.size(), 32'd4);
        if (grants.size() >= 4) begin
            check("arb_g0", grants[0], 32'd0);
            check("arb_g1", grants[1], 32'd1);
            check("arb_g2", grants[2], 32'd0);
            check("arb_g3", grants[3], 32'd1);
        end

        // 5. back-pressure on a compare result
        step();
        rsp_ready = 1'b0;
        issue(0, 16'h1234, 16'h1234, 4'b1001);
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) break;
            step();
        end
        req_a[W +: W] = 16'h0001;
        req_b[W +: W] = 16'h0001;
        req_fun[7:4]  = 4'b0000;
        req_valid     = 2'b10;
        repeat (5) begin
            @(negedge CLK);
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_data", rsp_data, 32'h0000_0001);
            check("bp_busy", {31'd0, busy}, 32'd1);
            check("bp_req_ready", {30'd0, req_ready}, 32'd0);
        end
        check("bp_no_handshake", rsp_count, 32'd6);
        step();
        rsp_ready = 1'b1;
        wait_rsp(7);
        check("bp_cmp_flag", {31'd0, last_flag}, 32'd1);
        wait_accept(1);
        wait_rsp(8);
        check("bp_next_data", last_data, 32'h0000_0002);

        // 6a. reset during WAIT abandons the op
        step();
        issue(0, 16'h0003, 16'h0004, 4'b0000);
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_op_count", {16'd0, op_count}, 32'd0);
        sb.delete();
        base = rsp_count;
        repeat (6) step();
        check("midrst_no_rsp", rsp_count, base);

        // 6b. counter wrap, combined with immediate grant of requester 1 after reset
        force dut.op_count = 16'hFFFF;
        step();
        release dut.op_count;
        @(negedge CLK);
        check("wrap_preload", {16'd0, op_count}, 32'h0000_FFFF);
        step();
        req_a[W +: W] = 16'h0002;
        req_b[W +: W] = 16'h0003;
        req_fun[7:4]  = 4'b0010;
        req_valid     = 2'b10;
        @(negedge CLK);
        check("rr_req1_immediate", {30'd0, req_ready}, 32'd2);
        step();
        req_valid = 2'b00;
        wait_rsp(base + 1);
        check("wrap_data", last_data, 32'h0000_0006);
        check("wrap_op_count", {16'd0, op_count}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
